// File: rtl/yd_dbus_resp.sv
// yd_dbus_resp: Yduck data-bus responder with internal data RAM and programmable wait states.
// Define YD_DBUS_ERR_EN to add the err port and out-of-range access suppression.
module yd_dbus_resp #(
    parameter int DEPTH    = 256,
    parameter int AW       = 8,
    parameter int WAIT_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic [3:0]  rtag,
    output logic        dsv,
    output logic        ack,
    output logic        rvalid,
    output logic [15:0] rdata,
    output logic [3:0]  rwaddr
`ifdef YD_DBUS_ERR_EN
    ,
    output logic        err
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

    state_t          state_r;
    state_t          state_nxt_s;
    logic [3:0]      cnt_r;
    logic [3:0]      cnt_nxt_s;
    logic            accept_s;
    logic            enter_done_s;

    logic            we_r;
    logic [AW-1:0]   addr_r;
    logic [15:0]     wdata_r;
    logic [3:0]      rtag_r;
    logic            oor_r;
    logic            oor_s;

    logic            acc_we_s;
    logic [AW-1:0]   acc_addr_s;
    logic [15:0]     acc_wdata_s;
    logic [3:0]      acc_tag_s;
    logic            acc_oor_s;

    logic [15:0]     ram [DEPTH];
    logic [15:0]     ram_rd_s;

`ifdef YD_DBUS_ERR_EN
    assign oor_s = ({1'b0, addr} >= 17'(DEPTH));
`else
    assign oor_s = 1'b0;
`endif

    // Upper address bits only matter for range checking; otherwise addresses wrap.
    generate
        if (AW < 16) begin : g_hi
            logic unused_hi_s;
            assign unused_hi_s = ^addr[15:AW];
        end
    endgenerate

    // Next-state, wait counter and stall indication
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        accept_s    = 1'b0;
        dsv         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                dsv = req;
                if (req) begin
                    accept_s  = 1'b1;
                    cnt_nxt_s = WAIT_LD;
                    if (WAIT_LD != 4'd0) begin
                        state_nxt_s = ST_WAIT;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                dsv       = 1'b1;
                cnt_nxt_s = cnt_r - 4'd1;
                if (cnt_r <= 4'd1) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                dsv         = 1'b0;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    assign enter_done_s = (state_nxt_s == ST_DONE);

    // With zero wait states the access completes straight from IDLE, so use live inputs
    always_comb begin
        acc_we_s    = we_r;
        acc_addr_s  = addr_r;
        acc_wdata_s = wdata_r;
        acc_tag_s   = rtag_r;
        acc_oor_s   = oor_r;
        if (accept_s) begin
            acc_we_s    = we;
            acc_addr_s  = addr[AW-1:0];
            acc_wdata_s = wdata;
            acc_tag_s   = rtag;
            acc_oor_s   = oor_s;
        end else begin
            acc_we_s    = we_r;
            acc_addr_s  = addr_r;
            acc_wdata_s = wdata_r;
            acc_tag_s   = rtag_r;
            acc_oor_s   = oor_r;
        end
    end

    // Data RAM: contents survive reset; a write lands on the edge entering DONE
    always_ff @(posedge clk) begin
        if (rst_n && enter_done_s && acc_we_s && !acc_oor_s) begin
            ram[acc_addr_s] <= acc_wdata_s;
        end
    end

    assign ram_rd_s = ram[acc_addr_s];

    // State, request latch and registered response outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= 16'h0000;
            rtag_r  <= 4'h0;
            oor_r   <= 1'b0;
            ack     <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= 16'h0000;
            rwaddr  <= 4'h0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (accept_s) begin
                we_r    <= we;
                addr_r  <= addr[AW-1:0];
                wdata_r <= wdata;
                rtag_r  <= rtag;
                oor_r   <= oor_s;
            end
            ack    <= enter_done_s;
            rvalid <= enter_done_s & ~acc_we_s;
            if (enter_done_s && !acc_we_s) begin
                rdata  <= acc_oor_s ? 16'h0000 : ram_rd_s;
                rwaddr <= acc_tag_s;
            end
        end
    end

`ifdef YD_DBUS_ERR_EN
    // Error flag accompanies ack for out-of-range accesses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= enter_done_s & acc_oor_s;
        end
    end
`endif

endmodule

// File: tb/tb_yd_dbus_resp.sv
// Scoreboard bench for yd_dbus_resp: default-wait instance plus a zero-wait instance.
module tb_yd_dbus_resp;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we;
    logic [15:0] addr, wdata;
    logic [3:0]  rtag;
    logic        dsv, ack, rvalid;
    logic [15:0] rdata;
    logic [3:0]  rwaddr;

    logic        z_req, z_we;
    logic [15:0] z_addr, z_wdata;
    logic [3:0]  z_rtag;
    logic        z_dsv, z_ack, z_rvalid;
    logic [15:0] z_rdata;
    logic [3:0]  z_rwaddr;
`ifdef YD_DBUS_ERR_EN
    logic        err, z_err;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic        rd;
        logic [15:0] data;
        logic [3:0]  tag;
        logic        err;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic [15:0] mem [256];
    logic [15:0] last_rd = 16'h0000;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    yd_dbus_resp #(.DEPTH(256), .AW(8), .WAIT_CYC(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rtag(rtag), .dsv(dsv), .ack(ack), .rvalid(rvalid), .rdata(rdata), .rwaddr(rwaddr)
`ifdef YD_DBUS_ERR_EN
        , .err(err)
`endif
    );

    yd_dbus_resp #(.DEPTH(256), .AW(8), .WAIT_CYC(0)) u_zw (
        .clk(clk), .rst_n(rst_n), .req(z_req), .we(z_we), .addr(z_addr), .wdata(z_wdata),
        .rtag(z_rtag), .dsv(z_dsv), .ack(z_ack), .rvalid(z_rvalid), .rdata(z_rdata),
        .rwaddr(z_rwaddr)
`ifdef YD_DBUS_ERR_EN
        , .err(z_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Response monitor: pops the scoreboard on every ack
    always @(negedge clk) begin
        if (!rst_n) begin
            last_rd = 16'h0000;
        end else if (ack) begin
            if (sb.size() == 0) begin
                chk("spurious_ack", ack, 1'b0);
            end else begin
                cur = sb.pop_front();
                chk("ack_cycle", cyc, cur.due);
                chk("rvalid", rvalid, cur.rd);
                if (cur.rd) begin
                    chk("rdata", rdata, cur.data);
                    chk("rwaddr", rwaddr, cur.tag);
                    last_rd = cur.data;
                end else begin
                    chk("rdata_hold", rdata, last_rd);
                end
`ifdef YD_DBUS_ERR_EN
                chk("err", err, cur.err);
`endif
            end
        end else if (rvalid) begin
            chk("rvalid_no_ack", rvalid, 1'b0);
        end
    end

    task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                          input logic [3:0] t, input bit poke, input string tag);
        exp_t e;
        logic oor;
        oor = 1'b0;
`ifdef YD_DBUS_ERR_EN
        oor = (a >= 16'd256);
`endif
        @(posedge clk); #1;
        req = 1'b1; we = w; addr = a; wdata = d; rtag = t;
        e.rd  = ~w;
        e.tag = t;
        e.err = oor;
        e.due = cyc + 1 + W;
        if (w) begin
            if (!oor) mem[a[7:0]] = d;
            e.data = 16'h0000;
        end else begin
            e.data = oor ? 16'h0000 : mem[a[7:0]];
        end
        sb.push_back(e);
        @(negedge clk);
        chk({tag, "_dsv_req"}, dsv, 1'b1);
        @(posedge clk); #1;
        req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk({tag, "_dsv"}, dsv, (cyc < e.due) ? 1'b1 : 1'b0);
            if (cyc >= e.due) begin
                if (poke) begin
                    req = 1'b1; we = 1'b0; addr = 16'h0010; rtag = 4'h3;
                    #1;
                    chk({tag, "_dsv_in_done"}, dsv, 1'b0);
                    @(posedge clk); #1;
                    req = 1'b0;
                end
                break;
            end
        end
        @(negedge clk);
        chk({tag, "_drained"}, sb.size(), 0);
        if (poke) begin
            for (int i = 0; i < 4; i++) begin
                chk({tag, "_dropped_no_ack"}, ack, 1'b0);
                chk({tag, "_idle_dsv"}, dsv, 1'b0);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = 16'h0; wdata = 16'h0; rtag = 4'h0;
        z_req = 1'b0; z_we = 1'b0; z_addr = 16'h0; z_wdata = 16'h0; z_rtag = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dsv", dsv, 1'b0);
        chk("rst_ack", ack, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rdata", rdata, 16'h0);
        chk("rst_rwaddr", rwaddr, 4'h0);
        chk("rst_z_ack", z_ack, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        access(1'b1, 16'h0010, 16'hBEEF, 4'h0, 1'b0, "wr_beef");
        access(1'b0, 16'h0010, 16'h0000, 4'h5, 1'b0, "rd_beef");
        access(1'b1, 16'h0003, 16'h1111, 4'h0, 1'b0, "wr_a3");
        access(1'b0, 16'h0003, 16'h0000, 4'h2, 1'b0, "rd_a3");
        access(1'b1, 16'h00FF, 16'hC3C3, 4'h0, 1'b0, "wr_top");
        access(1'b0, 16'h00FF, 16'h0000, 4'hF, 1'b0, "rd_top");
`ifndef YD_DBUS_ERR_EN
        access(1'b1, 16'h0105, 16'h1234, 4'h0, 1'b0, "wr_wrap");
        access(1'b0, 16'h0005, 16'h0000, 4'hA, 1'b0, "rd_wrap");
`endif

        // Reset while the write to address 3 is waiting
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = 16'h0003; wdata = 16'hAAAA;
        @(posedge clk); #1;
        req = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_dsv", dsv, 1'b0);
        chk("midrst_ack", ack, 1'b0);
        chk("midrst_rvalid", rvalid, 1'b0);
        chk("midrst_rdata", rdata, 16'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_no_ack", ack, 1'b0);
        end
        access(1'b0, 16'h0003, 16'h0000, 4'h9, 1'b0, "rd_after_rst");

        access(1'b0, 16'h0010, 16'h0000, 4'h1, 1'b1, "req_in_done");

`ifdef YD_DBUS_ERR_EN
        access(1'b1, 16'h0000, 16'h0A0A, 4'h0, 1'b0, "wr_a0");
        access(1'b1, 16'h0100, 16'h5555, 4'h0, 1'b0, "wr_oor");
        access(1'b0, 16'h0100, 16'h0000, 4'h4, 1'b0, "rd_oor");
        access(1'b0, 16'h0000, 16'h0000, 4'h6, 1'b0, "rd_a0");
`endif

        // Zero-wait instance: back-to-back accesses every two cycles
        @(posedge clk); #1;
        z_req = 1'b1; z_we = 1'b1; z_addr = 16'h0020; z_wdata = 16'h0F0F; z_rtag = 4'h0;
        @(negedge clk);
        chk("z_t0_dsv", z_dsv, 1'b1);
        chk("z_t0_ack", z_ack, 1'b0);
        @(posedge clk); #1;
        z_req = 1'b0;
        @(negedge clk);
        chk("z_t1_dsv", z_dsv, 1'b0);
        chk("z_t1_ack", z_ack, 1'b1);
        chk("z_t1_rvalid", z_rvalid, 1'b0);
        @(posedge clk); #1;
        z_req = 1'b1; z_we = 1'b0; z_rtag = 4'h7;
        @(negedge clk);
        chk("z_t2_dsv", z_dsv, 1'b1);
        chk("z_t2_ack", z_ack, 1'b0);
        @(posedge clk); #1;
        z_req = 1'b0;
        @(negedge clk);
        chk("z_t3_ack", z_ack, 1'b1);
        chk("z_t3_rvalid", z_rvalid, 1'b1);
        chk("z_t3_rdata", z_rdata, 16'h0F0F);
        chk("z_t3_rwaddr", z_rwaddr, 4'h7);
        chk("z_t3_dsv", z_dsv, 1'b0);
        @(negedge clk);
        chk("z_t4_ack", z_ack, 1'b0);

        repeat (2) @(negedge clk);
        chk("final_sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
